matmul_loader: RTL
==================

MATMUL_LOADER -- requirements
Module: matmul_loader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the element width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6, meaning the memory address width.
REQ-003 The block SHALL have parameter TN, default 8, meaning the matrix dimension; N = TN*TN elements per matrix, and N <= 2**ADDR_WIDTH SHALL hold.
REQ-004 The block SHALL have port clock, input, 1 bit, the clock.
REQ-005 The block SHALL have port reset, input, 1 bit, the reset, asynchronous, active-high.
REQ-006 The block SHALL have in_data/in_valid/in_ready, input/input/output, DATA_WIDTH/1/1, the host load stream (X row-major, then Y row-major).
REQ-007 The block SHALL have out_data/out_valid/out_ready/out_last, output/output/input/output, DATA_WIDTH/1/1/1, the Z result stream, row-major.
REQ-008 The block SHALL have x_din/x_addr/x_wr_en, output, DATA_WIDTH/ADDR_WIDTH/1, the X memory write port.
REQ-009 The block SHALL have y_din/y_addr/y_wr_en, output, DATA_WIDTH/ADDR_WIDTH/1, the Y memory write port.
REQ-010 The block SHALL have z_addr (output, ADDR_WIDTH) and z_dout (input, DATA_WIDTH), the Z memory read port with 1-cycle synchronous read latency.
REQ-011 The block SHALL have mm_start (output, 1), mm_done (input, 1) and busy (output, 1), the multiplier handshake and a busy indicator.

Function
REQ-012 The FSM SHALL have states LOAD_X, LOAD_Y, START, WAIT, DRAIN_RD and DRAIN_OUT, plus an ADDR_WIDTH-bit element counter cnt.
REQ-013 in_ready SHALL be 1 only in LOAD_X and LOAD_Y.
REQ-014 Each accepted word (in_valid && in_ready) SHALL drive, in the same cycle, wr_en=1, addr=cnt, din=in_data on the X port (LOAD_X) or the Y port (LOAD_Y); cnt SHALL increment.
REQ-015 An accept at cnt==N-1 SHALL clear cnt and move LOAD_X->LOAD_Y or LOAD_Y->START.
REQ-016 With in_valid low, state and cnt SHALL hold and no write SHALL occur.
REQ-017 START SHALL last exactly one cycle with mm_start=1, then go to WAIT; mm_start SHALL be 0 in every other state.
REQ-018 WAIT SHALL sample mm_done from its first cycle, because the multiplier clears done on the edge that samples start; when mm_done==1 the FSM SHALL go to DRAIN_RD with cnt=0.
REQ-019 z_addr SHALL equal cnt in DRAIN_RD and DRAIN_OUT, and 0 otherwise.
REQ-020 DRAIN_RD SHALL last one cycle and then go to DRAIN_OUT.
REQ-021 In DRAIN_OUT: out_valid=1, out_data=z_dout, out_last=(cnt==N-1); out_data SHALL stay stable while out_ready is low.
REQ-022 On out_ready in DRAIN_OUT: if out_last, go to LOAD_X with cnt=0; otherwise increment cnt and go to DRAIN_RD. Minimum drain rate SHALL be 1 word per 2 cycles.
REQ-023 out_valid, out_last and out_data SHALL be 0 outside DRAIN_OUT.
REQ-024 busy SHALL be 0 only in LOAD_X with cnt==0.
REQ-025 in_valid during START, WAIT or drain states SHALL be ignored (in_ready=0).
REQ-026 mm_done high in any state other than WAIT SHALL be ignored.
REQ-027 No arithmetic SHALL be performed on data; cnt SHALL compare against N-1 and never wrap past it.

Reset
REQ-028 Reset SHALL force state=LOAD_X, cnt=0, all outputs 0 except in_ready=1; memory contents are not cleared.
REQ-029 Reset mid-load, mid-wait or mid-drain SHALL abandon the transfer, with no partial write after reset and out_valid=0 immediately.

Structure
REQ-030 The state enum and the derived constant N SHALL reside in package matmul_pkg, shared with the multiplier.
REQ-031 The block SHALL be a single module with no sub-modules; X/Y memories are external dual-port, with this block on the write side and the multiplier on the read side.

Verification
REQ-032 Load X=identity and Y[k]=k for k=0..63 with in_valid held high -> 128 writes, mm_start is 1 exactly one cycle after the 128th accept, and with a multiplier model Z drains as 0..63 with out_last on word 63.
REQ-033 Random in_valid gaps (50%) during load -> addresses 0..63 are written exactly once per port, in order.
REQ-034 out_ready held low for 10 cycles on word 5 -> out_data stays stable and equal to Z[5], with no skip or duplicate.
REQ-035 out_ready always 1 -> 64-word drain completes in 128 cycles, then busy=0 and in_ready=1.
REQ-036 Reset asserted at load word 30, then a full reload -> writes restart at address 0 and mm_start fires once.
REQ-037 mm_done held high during LOAD_X -> no state change and no drain.

Source files
------------

// File: rtl/matmul_pkg.sv
// Package shared by the matrix loader and the multiplier.
//   mm_state_t  : loader FSM state encoding
//   TN_DEFAULT  : default matrix dimension
//   elem_count  : elements per square matrix of dimension tn
//   N           : element count for the default dimension
package matmul_pkg;

  typedef enum logic [2:0] {
    LOAD_X,
    LOAD_Y,
    START,
    WAIT,
    DRAIN_RD,
    DRAIN_OUT
  } mm_state_t;

  localparam int unsigned TN_DEFAULT = 8;

  function automatic int unsigned elem_count(input int unsigned tn);
    return tn * tn;
  endfunction

  localparam int unsigned N = elem_count(TN_DEFAULT);

endpackage

// File: rtl/matmul_loader.sv
// Host-side sequencer for a TN x TN matrix multiplier.
// Streams X then Y (row-major) from the host into the external X/Y
// memories, pulses mm_start, waits for mm_done, then streams Z out of the
// Z memory (row-major) with a valid/ready handshake.
//   clock, reset                     : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready        : host load stream
//   out_data/out_valid/out_ready/out_last : Z result stream
//   x_din/x_addr/x_wr_en             : X memory write port
//   y_din/y_addr/y_wr_en             : Y memory write port
//   z_addr/z_dout                    : Z memory read port (1-cycle latency)
//   mm_start/mm_done                 : multiplier handshake
//   busy                             : low only when idle at start of X load
module matmul_loader
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned TN         = TN_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic                  x_wr_en,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  y_wr_en,
  output logic [ADDR_WIDTH-1:0] z_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic                  mm_start,
  input  logic                  mm_done,
  output logic                  busy
);

  localparam int unsigned           N_ELEM   = elem_count(TN);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(N_ELEM - 1);

  mm_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  at_last;
  logic                  wr_ok;

  assign at_last = (cnt == CNT_LAST);
  // Reset holds the FSM in LOAD_X where in_ready is high; gating the write
  // strobe keeps a word presented during reset from reaching memory.
  assign wr_ok   = in_valid && !reset;
  assign busy    = !((state == LOAD_X) && (cnt == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= LOAD_X;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    x_wr_en   = 1'b0;
    x_addr    = '0;
    x_din     = '0;
    y_wr_en   = 1'b0;
    y_addr    = '0;
    y_din     = '0;
    z_addr    = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    mm_start  = 1'b0;

    case (state)
      LOAD_X: begin
        in_ready = 1'b1;
        if (wr_ok) begin
          x_wr_en = 1'b1;
          x_addr  = cnt;
          x_din   = in_data;
          if (at_last) begin
            cnt_nxt   = '0;
            state_nxt = LOAD_Y;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      LOAD_Y: begin
        in_ready = 1'b1;
        if (wr_ok) begin
          y_wr_en = 1'b1;
          y_addr  = cnt;
          y_din   = in_data;
          if (at_last) begin
            cnt_nxt   = '0;
            state_nxt = START;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      START: begin
        mm_start  = 1'b1;
        state_nxt = WAIT;
      end

      // The multiplier drops done on the edge that samples start, so a high
      // done seen here is always the fresh completion.
      WAIT: begin
        if (mm_done) begin
          cnt_nxt   = '0;
          state_nxt = DRAIN_RD;
        end
      end

      DRAIN_RD: begin
        z_addr    = cnt;
        state_nxt = DRAIN_OUT;
      end

      // z_addr stays on cnt, so the synchronous read keeps z_dout stable
      // for as long as the consumer stalls.
      DRAIN_OUT: begin
        z_addr    = cnt;
        out_valid = 1'b1;
        out_data  = z_dout;
        out_last  = at_last;
        if (out_ready) begin
          if (at_last) begin
            cnt_nxt   = '0;
            state_nxt = LOAD_X;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = DRAIN_RD;
          end
        end
      end

      default: begin
        cnt_nxt   = '0;
        state_nxt = LOAD_X;
      end
    endcase
  end

endmodule
